ps2_host_tx: RTL

Host-to-device PS/2 transmitter: the sending counterpart of the keyboard receive path. It lets the FPGA send command bytes to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset). It drives the PS2_CLK and PS2_DATA lines open-drain through output-enable signals at top level, and reports ACK, NACK or timeout per byte. While it runs, `busy` is high; top level uses it to mask the receiver.

---
 rtl/ps2_host_tx_if.sv | 29 ++
 rtl/ps2_host_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: bundles the command handshake, status strobes and the PS/2
// line sense/drive signals of the host transmitter.
//   tx_data/tx_valid/tx_ready    : command byte handshake
//   tx_done/tx_err/busy          : per-frame status
//   ps2_clk_in/ps2_data_in       : raw line levels from the pads
//   ps2_clk_oe/ps2_data_oe       : 1 pulls the line low, 0 releases it
// slave is the transmitter's view; master is the environment's view.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Inhibits the bus, issues a
// request-to-send, then shifts out 8 data bits, odd parity and stop on the
// device's falling clock edges, and checks the device ACK.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset; releases the bus immediately
//   bus      : ps2_host_tx_if.slave (handshake, status, line sense/drive)
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned FltW   = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StSend,
        StAck,
        StWaitIdle
    } state_e;

    // Line conditioning: index 0 is the clock line, index 1 the data line.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      filt_q, filt_d;
    logic [FltW-1:0] flt_cnt_q [2];
    logic [FltW-1:0] flt_cnt_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i]    = filt_q[i];
            flt_cnt_d[i] = '0;
            // Count consecutive samples that disagree with the filtered value.
            if (sync2_q[i] != filt_q[i]) begin
                if (flt_cnt_q[i] == FltW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    flt_cnt_d[i] = flt_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                flt_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= {bus.ps2_data_in, bus.ps2_clk_in};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            for (int i = 0; i < 2; i++) begin
                flt_cnt_q[i] <= flt_cnt_d[i];
            end
        end
    end

    logic fall;
    logic clk_edge;
    assign fall     = filt_q[0] & ~filt_d[0];
    assign clk_edge = filt_q[0] ^ filt_d[0];

    // Frame state.
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;          // inhibit timer, then device-clock gap timer
    logic [9:0]      shift_q, shift_d;      // {stop, parity, data}, LSB goes out first
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic            data_oe_q, data_oe_d;
    logic            acked_q, acked_d;
    logic            ready_en_q;            // keeps tx_ready low while in reset
    logic            tx_ready;
    logic            accept;
    logic            timeout;

    assign tx_ready = ready_en_q & (state_q == StIdle);
    assign accept   = bus.tx_valid & tx_ready;
    assign timeout  = (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_oe_d   = data_oe_q;
        acked_d     = acked_q;
        bus.tx_done = 1'b0;
        bus.tx_err  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    acked_d   = 1'b0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;   // start bit goes out together with START
                    state_d   = StStart;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                cnt_d = clk_edge ? '0 : cnt_q + 1'b1;
                if (timeout) begin
                    bus.tx_err = 1'b1;
                    data_oe_d  = 1'b0;
                    state_d    = StIdle;
                end else if (fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                cnt_d = clk_edge ? '0 : cnt_q + 1'b1;
                if (timeout) begin
                    bus.tx_err = 1'b1;
                    data_oe_d  = 1'b0;
                    state_d    = StIdle;
                end else if (fall) begin
                    if (!filt_q[1]) begin
                        acked_d = 1'b1;
                    end else begin
                        bus.tx_err = 1'b1;
                    end
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                cnt_d = clk_edge ? '0 : cnt_q + 1'b1;
                if (timeout) begin
                    // A NACKed frame has already reported its error.
                    bus.tx_err = acked_q;
                    data_oe_d  = 1'b0;
                    state_d    = StIdle;
                end else if (filt_q[0] && filt_q[1]) begin
                    bus.tx_done = acked_q;
                    state_d     = StIdle;
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            data_oe_q  <= 1'b0;
            acked_q    <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            data_oe_q  <= data_oe_d;
            acked_q    <= acked_d;
            ready_en_q <= 1'b1;
        end
    end

    assign bus.tx_ready    = tx_ready;
    assign bus.busy        = (state_q != StIdle);
    assign bus.ps2_clk_oe  = (state_q == StInhibit) || (state_q == StStart);
    assign bus.ps2_data_oe = data_oe_q;

endmodule
